// File: rtl/diff_core_pkg.sv
// Shared types and buffer geometry for the diff core read path.
// Buffer depths set the address counter wrap points.
package diff_core_pkg;

    localparam int FM_BUF_DEPTH    = 16;
    localparam int GUARD_BUF_DEPTH = 8;
    localparam int GROUP_N         = 6;

    // Packed mode pulls three bytes, two nibble-elements each.
    localparam logic [2:0] NIBBLE_BYTES = 3'd3;
    localparam logic [5:0] FULL_MASK    = 6'b111111;

    typedef enum logic [2:0] {
        IDLE,
        G_RD,
        G_WAIT,
        FETCH,
        OUT,
        DONE
    } fsm_state_t;

    typedef logic [GROUP_N-1:0][7:0] group_t;

endpackage

// File: rtl/guard_popcount6.sv
// Combinational: popcount of a 6-bit guard and index of the highest set bit of mask & ~filled.
// Zero latency, no backpressure.
// sel_idx is 0 when nothing is open; callers only use it while a fill is pending.
module guard_popcount6 (
    input  logic [5:0] cnt_vec,
    input  logic [5:0] mask,
    input  logic [5:0] filled,
    output logic [2:0] count,
    output logic [2:0] sel_idx
);

    logic [5:0] open_bits;

    always_comb begin
        count     = '0;
        sel_idx   = '0;
        open_bits = mask & ~filled;
        for (int i = 0; i < 6; i++) begin
            count = count + {2'b00, cnt_vec[i]};
            // ascending scan so the highest open bit wins
            if (open_bits[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/fm_guard_unpack_read.sv
// Reads a guard mask per group and expands sparse (8-bit) or nibble-packed (4-bit) fm bytes into 6-element groups.
// Latency: G_RD + G_WAIT + (popcount + 1) fetch cycles per group in 8-bit mode; 4 fetch cycles in 4-bit mode.
// Backpressure: data_o_ready low holds the group in OUT with no further buffer reads.
module fm_guard_unpack_read
    import diff_core_pkg::*;
#(
    parameter int FM_ADDR_W    = $clog2(FM_BUF_DEPTH),
    parameter int GUARD_ADDR_W = $clog2(GUARD_BUF_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ctrl_valid,
    output logic                    ctrl_ready,
    output logic                    ctrl_finish,
    input  logic [15:0]             pace_i,
    input  logic                    bit_mode_i,
    output logic [GUARD_ADDR_W-1:0] guard_addr_o,
    output logic                    guard_rd_en,
    input  logic [5:0]              guard_i,
    output logic [FM_ADDR_W-1:0]    fm_addr_o,
    output logic                    fm_rd_en,
    input  logic [7:0]              fm_data_i,
    output logic [5:0][7:0]         data_o,
    output logic [5:0]              guard_o,
    output logic                    data_o_valid,
    input  logic                    data_o_ready
);

    fsm_state_t              state_q;
    logic [15:0]             pace_q;
    logic                    mode_q;
    logic [5:0]              mask_q;
    logic [5:0]              filled_q;
    logic [2:0]              pending_q;
    logic [2:0]              issued_q;
    logic                    rd_pend_q;
    group_t                  data_q;
    logic [GUARD_ADDR_W-1:0] guard_addr_q;
    logic [FM_ADDR_W-1:0]    fm_addr_q;

    logic [2:0]              guard_cnt;
    logic [2:0]              sel_idx;

    guard_popcount6 u_popcount (
        .cnt_vec (guard_i),
        .mask    (mask_q),
        .filled  (filled_q),
        .count   (guard_cnt),
        .sel_idx (sel_idx)
    );

    assign ctrl_ready   = (state_q == IDLE);
    assign ctrl_finish  = (state_q == DONE);
    assign guard_rd_en  = (state_q == G_RD);
    assign guard_addr_o = guard_addr_q;
    assign fm_rd_en     = (state_q == FETCH) && (issued_q < pending_q);
    assign fm_addr_o    = fm_addr_q;
    assign data_o_valid = (state_q == OUT);
    assign data_o       = (state_q == OUT) ? data_q : '0;
    assign guard_o      = (state_q == OUT) ? mask_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pace_q       <= '0;
            mode_q       <= 1'b0;
            mask_q       <= '0;
            filled_q     <= '0;
            pending_q    <= '0;
            issued_q     <= '0;
            rd_pend_q    <= 1'b0;
            data_q       <= '0;
            guard_addr_q <= '0;
            fm_addr_q    <= '0;
        end else begin
            // a read issued this cycle returns data on the next one
            rd_pend_q <= fm_rd_en;

            case (state_q)
                IDLE: begin
                    if (ctrl_valid) begin
                        pace_q       <= pace_i;
                        mode_q       <= bit_mode_i;
                        guard_addr_q <= '0;
                        fm_addr_q    <= '0;
                        if (pace_i == 16'd0) begin
                            state_q <= DONE;
                        end else if (bit_mode_i) begin
                            mask_q    <= FULL_MASK;
                            pending_q <= NIBBLE_BYTES;
                            issued_q  <= '0;
                            filled_q  <= '0;
                            data_q    <= '0;
                            state_q   <= FETCH;
                        end else begin
                            state_q <= G_RD;
                        end
                    end
                end

                G_RD: begin
                    if (guard_addr_q == GUARD_ADDR_W'(GUARD_BUF_DEPTH - 1)) begin
                        guard_addr_q <= '0;
                    end else begin
                        guard_addr_q <= guard_addr_q + 1'b1;
                    end
                    state_q <= G_WAIT;
                end

                G_WAIT: begin
                    mask_q    <= guard_i;
                    pending_q <= guard_cnt;
                    issued_q  <= '0;
                    filled_q  <= '0;
                    data_q    <= '0;
                    state_q   <= (guard_i == 6'd0) ? OUT : FETCH;
                end

                FETCH: begin
                    if (fm_rd_en) begin
                        issued_q <= issued_q + 1'b1;
                        if (fm_addr_q == FM_ADDR_W'(FM_BUF_DEPTH - 1)) begin
                            fm_addr_q <= '0;
                        end else begin
                            fm_addr_q <= fm_addr_q + 1'b1;
                        end
                    end
                    if (rd_pend_q) begin
                        // with a full mask, sel_idx walks 5,3,1 in packed mode
                        if (mode_q) begin
                            data_q[sel_idx]        <= {4'h0, fm_data_i[7:4]};
                            data_q[sel_idx - 3'd1] <= {4'h0, fm_data_i[3:0]};
                            filled_q <= filled_q | (6'b1 << sel_idx) | (6'b1 << (sel_idx - 3'd1));
                        end else begin
                            data_q[sel_idx] <= fm_data_i;
                            filled_q        <= filled_q | (6'b1 << sel_idx);
                        end
                        if (issued_q == pending_q) begin
                            state_q <= OUT;
                        end
                    end
                end

                OUT: begin
                    if (data_o_ready) begin
                        pace_q <= pace_q - 16'd1;
                        if (pace_q == 16'd1) begin
                            state_q <= DONE;
                        end else if (mode_q) begin
                            mask_q    <= FULL_MASK;
                            pending_q <= NIBBLE_BYTES;
                            issued_q  <= '0;
                            filled_q  <= '0;
                            data_q    <= '0;
                            state_q   <= FETCH;
                        end else begin
                            state_q <= G_RD;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fm_guard_unpack_read.sv
// Directed bench for fm_guard_unpack_read with behavioural 1-cycle-latency guard and fm buffers.
module tb_fm_guard_unpack_read;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrl_finish;
    logic [15:0] pace_i;
    logic        bit_mode_i;
    logic [2:0]  guard_addr_o;
    logic        guard_rd_en;
    logic [5:0]  guard_i;
    logic [3:0]  fm_addr_o;
    logic        fm_rd_en;
    logic [7:0]  fm_data_i;
    logic [5:0][7:0] data_o;
    logic [5:0]  guard_o;
    logic        data_o_valid;
    logic        data_o_ready;

    logic [5:0] guard_mem [0:7];
    logic [7:0] fm_mem [0:15];
    int         fm_rd_cnt = 0;
    int         guard_rd_cnt = 0;
    logic [3:0] fm_log [$];

    int errors = 0;
    int checks = 0;

    fm_guard_unpack_read dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .ctrl_finish  (ctrl_finish),
        .pace_i       (pace_i),
        .bit_mode_i   (bit_mode_i),
        .guard_addr_o (guard_addr_o),
        .guard_rd_en  (guard_rd_en),
        .guard_i      (guard_i),
        .fm_addr_o    (fm_addr_o),
        .fm_rd_en     (fm_rd_en),
        .fm_data_i    (fm_data_i),
        .data_o       (data_o),
        .guard_o      (guard_o),
        .data_o_valid (data_o_valid),
        .data_o_ready (data_o_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (guard_rd_en) begin
            guard_i <= guard_mem[guard_addr_o];
            guard_rd_cnt++;
        end
        if (fm_rd_en) begin
            fm_data_i <= fm_mem[fm_addr_o];
            fm_rd_cnt++;
            fm_log.push_back(fm_addr_o);
        end
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] pace, input logic mode);
        @(negedge clk);
        ctrl_valid = 1'b1;
        pace_i     = pace;
        bit_mode_i = mode;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!data_o_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 48'(data_o_valid), 48'd1);
    endtask

    task automatic wait_finish(input string tag);
        int n = 0;
        while (!ctrl_finish && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 48'(ctrl_finish), 48'd1);
    endtask

    initial begin
        int fm_base;
        int g_base;
        int log_base;
        logic [23:0] addr_seq;
        logic [47:0] held;

        rst_n        = 1'b0;
        ctrl_valid   = 1'b0;
        pace_i       = '0;
        bit_mode_i   = 1'b0;
        data_o_ready = 1'b1;
        for (int i = 0; i < 8; i++) guard_mem[i] = '0;
        for (int i = 0; i < 16; i++) fm_mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl_ready", 48'(ctrl_ready), 48'd1);
        chk("rst_valid", 48'(data_o_valid), 48'd0);
        chk("rst_data", data_o, 48'd0);
        chk("rst_guard", 48'(guard_o), 48'd0);
        chk("rst_finish", 48'(ctrl_finish), 48'd0);
        chk("rst_rd_en", 48'({guard_rd_en, fm_rd_en}), 48'd0);
        rst_n = 1'b1;

        // 8-bit, sparse guard 100101
        guard_mem[0] = 6'b100101;
        fm_mem[0] = 8'h11; fm_mem[1] = 8'h22; fm_mem[2] = 8'h33;
        fm_base = fm_rd_cnt; g_base = guard_rd_cnt;
        start_job(16'd1, 1'b0);
        chk("t1_busy", 48'(ctrl_ready), 48'd0);
        wait_valid("t1_valid");
        chk("t1_data", data_o, 48'h11_00_00_22_00_33);
        chk("t1_guard", 48'(guard_o), 48'b100101);
        chk("t1_fm_reads", 48'(fm_rd_cnt - fm_base), 48'd3);
        chk("t1_g_reads", 48'(guard_rd_cnt - g_base), 48'd1);
        @(negedge clk);
        chk("t1_finish", 48'(ctrl_finish), 48'd1);
        @(negedge clk);
        chk("t1_finish_pulse", 48'(ctrl_finish), 48'd0);
        chk("t1_idle", 48'(ctrl_ready), 48'd1);

        // 8-bit, pace 2: empty guard then full guard
        guard_mem[0] = 6'b000000;
        guard_mem[1] = 6'b111111;
        for (int i = 0; i < 6; i++) fm_mem[i] = 8'(i + 1);
        fm_base = fm_rd_cnt; log_base = fm_log.size();
        start_job(16'd2, 1'b0);
        wait_valid("t2_g0_valid");
        chk("t2_g0_data", data_o, 48'd0);
        chk("t2_g0_guard", 48'(guard_o), 48'd0);
        chk("t2_g0_no_fm", 48'(fm_rd_cnt - fm_base), 48'd0);
        @(negedge clk);
        wait_valid("t2_g1_valid");
        chk("t2_g1_data", data_o, 48'h01_02_03_04_05_06);
        chk("t2_g1_guard", 48'(guard_o), 48'b111111);
        chk("t2_fm_reads", 48'(fm_rd_cnt - fm_base), 48'd6);
        addr_seq = '0;
        for (int i = 0; i < 6; i++) begin
            if (log_base + i < fm_log.size()) addr_seq = {addr_seq[19:0], fm_log[log_base + i]};
        end
        chk("t2_fm_addrs", 48'(addr_seq), 48'h012345);
        wait_finish("t2_finish");

        // 4-bit packed
        fm_mem[0] = 8'hA5; fm_mem[1] = 8'h3C; fm_mem[2] = 8'h01;
        fm_base = fm_rd_cnt; g_base = guard_rd_cnt;
        start_job(16'd1, 1'b1);
        wait_valid("t3_valid");
        chk("t3_data", data_o, 48'h0A_05_03_0C_00_01);
        chk("t3_guard", 48'(guard_o), 48'b111111);
        chk("t3_fm_reads", 48'(fm_rd_cnt - fm_base), 48'd3);
        chk("t3_no_guard_rd", 48'(guard_rd_cnt - g_base), 48'd0);
        wait_finish("t3_finish");

        // backpressure in OUT
        guard_mem[0] = 6'b000011;
        guard_mem[1] = 6'b110000;
        fm_mem[0] = 8'h44; fm_mem[1] = 8'h55; fm_mem[2] = 8'h66; fm_mem[3] = 8'h77;
        data_o_ready = 1'b0;
        start_job(16'd2, 1'b0);
        wait_valid("t4_g0_valid");
        chk("t4_g0_data", data_o, 48'h00_00_00_00_44_55);
        fm_base = fm_rd_cnt; g_base = guard_rd_cnt;
        held = data_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold", {data_o_valid, fm_rd_en, guard_rd_en, 45'(data_o)},
                {1'b1, 1'b0, 1'b0, 45'(held)});
        end
        chk("t4_hold_reads", 48'((fm_rd_cnt - fm_base) + (guard_rd_cnt - g_base)), 48'd0);
        data_o_ready = 1'b1;
        @(negedge clk);
        wait_valid("t4_g1_valid");
        chk("t4_g1_data", data_o, 48'h66_77_00_00_00_00);
        chk("t4_g1_guard", 48'(guard_o), 48'b110000);
        wait_finish("t4_finish");

        // pace 0
        fm_base = fm_rd_cnt; g_base = guard_rd_cnt;
        start_job(16'd0, 1'b0);
        chk("t5_finish", 48'(ctrl_finish), 48'd1);
        chk("t5_no_valid", 48'(data_o_valid), 48'd0);
        @(negedge clk);
        chk("t5_idle", 48'(ctrl_ready), 48'd1);
        chk("t5_no_reads", 48'((fm_rd_cnt - fm_base) + (guard_rd_cnt - g_base)), 48'd0);

        // reset mid-fetch, then a fresh job
        guard_mem[0] = 6'b111111;
        start_job(16'd1, 1'b0);
        begin
            int n = 0;
            while (!fm_rd_en && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        chk("t6_in_fetch", 48'(fm_rd_en), 48'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", 48'(ctrl_ready), 48'd1);
        chk("t6_rst_outs", {fm_rd_en, guard_rd_en, data_o_valid, ctrl_finish, 44'(data_o)}, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fm_mem[0] = 8'h12; fm_mem[1] = 8'h34; fm_mem[2] = 8'h56;
        log_base = fm_log.size();
        start_job(16'd1, 1'b1);
        wait_valid("t6_valid");
        chk("t6_data", data_o, 48'h01_02_03_04_05_06);
        chk("t6_first_addr", (log_base < fm_log.size()) ? 48'(fm_log[log_base]) : 48'hFFFF, 48'd0);
        wait_finish("t6_finish");

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
